// File: rtl/io_led_pwm_pkg.sv
// Shared constants and types for the IO LED PWM stage.
// Register offsets, reset values and the blink helper.
package io_led_pwm_pkg;

    localparam int NCH = 3;

    localparam logic [9:0] ADR_DUTY  = 10'd1;
    localparam logic [9:0] ADR_PRESC = 10'd2;
    localparam logic [9:0] ADR_BLINK = 10'd3;

    localparam logic [7:0] DUTY_RST  = 8'hFF;
    localparam logic [7:0] DUTY_FULL = 8'hFF;

    typedef logic [7:0] duty_t;

    typedef struct packed {
        logic       en;
        logic [7:0] half;
    } blink_cfg_t;

    // Last count value of a blink half-period; half=0 behaves as 1.
    function automatic logic [7:0] half_last(input logic [7:0] half);
        return (half == 8'd0) ? 8'd0 : half - 8'd1;
    endfunction

endpackage

// File: rtl/io_led_pwm_chan.sv
// One PWM channel: compares the frame counter with active duty.
// Duty 0 never lights, full duty always lights.
module io_led_pwm_chan
    import io_led_pwm_pkg::*;
(
    input  logic [7:0] pwm_cnt,
    input  logic [7:0] duty_act,
    output logic       on
);

    assign on = (pwm_cnt < duty_act) | (duty_act == DUTY_FULL);

endmodule

// File: rtl/io_led_pwm.sv
// RGB LED pin driver: per-channel 8-bit PWM plus optional blink.
// Config words arrive on the IO store bus at word offsets 1..3.
module io_led_pwm
    import io_led_pwm_pkg::*;
#(
    parameter bit OUT_INV = 1'b0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [3:0]     st_we_io,
    input  logic [9:0]     st_adr_io,
    input  logic [31:0]    st_data_io,
    input  logic [NCH-1:0] led_in,
    output logic [NCH-1:0] rgb_pwm
);

    duty_t            duty_pend [NCH];
    duty_t            duty_act  [NCH];
    logic [15:0]      prescale;
    logic [15:0]      presc_cnt;
    logic [7:0]       pwm_cnt;
    logic [7:0]       blink_cnt;
    blink_cfg_t       blink_cfg;
    logic             blink_phase;
    logic             tick;
    logic             frame_end;
    logic [NCH-1:0]   pwm_on;
    logic             wr_duty;
    logic             wr_presc;
    logic             wr_blink;
    logic             unused_bits;

    assign wr_duty  = (st_adr_io == ADR_DUTY);
    assign wr_presc = (st_adr_io == ADR_PRESC);
    assign wr_blink = (st_adr_io == ADR_BLINK);

    assign unused_bits = ^{st_data_io[31:24], st_we_io[3]};

    assign tick      = (presc_cnt >= prescale);
    assign frame_end = tick & (pwm_cnt == 8'hFF);

    // Byte-enabled config writes; duty lands in the pending copy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                duty_pend[i] <= DUTY_RST;
            end
            prescale  <= '0;
            blink_cfg <= '0;
        end else begin
            if (wr_duty) begin
                for (int i = 0; i < NCH; i++) begin
                    if (st_we_io[i]) begin
                        duty_pend[i] <= st_data_io[8*i +: 8];
                    end
                end
            end
            if (wr_presc && st_we_io[0]) prescale[7:0]  <= st_data_io[7:0];
            if (wr_presc && st_we_io[1]) prescale[15:8] <= st_data_io[15:8];
            if (wr_blink && st_we_io[0]) blink_cfg.en   <= st_data_io[0];
            if (wr_blink && st_we_io[1]) blink_cfg.half <= st_data_io[15:8];
        end
    end

    // Pending duty becomes active only on a frame boundary.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                duty_act[i] <= DUTY_RST;
            end
        end else if (frame_end) begin
            for (int i = 0; i < NCH; i++) begin
                duty_act[i] <= duty_pend[i];
            end
        end
    end

    // Prescaler and PWM frame counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_cnt <= '0;
            pwm_cnt   <= '0;
        end else begin
            presc_cnt <= tick ? 16'd0 : presc_cnt + 16'd1;
            if (tick) pwm_cnt <= pwm_cnt + 8'd1;
        end
    end

    // Blink phase toggles every max(half,1) frames while enabled.
    always_ff @(posedge clk) begin
        if (!rst_n || !blink_cfg.en) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (frame_end) begin
            if (blink_cnt >= half_last(blink_cfg.half)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 8'd1;
            end
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        io_led_pwm_chan u_chan (
            .pwm_cnt  (pwm_cnt),
            .duty_act (duty_act[i]),
            .on       (pwm_on[i])
        );
    end

    // Registered pin drive with optional polarity inversion.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rgb_pwm <= {NCH{OUT_INV}};
        end else begin
            rgb_pwm <= (led_in & pwm_on & {NCH{blink_phase}})
                       ^ {NCH{OUT_INV}};
        end
    end

endmodule

// File: tb/tb_io_led_pwm.sv
// Bench for io_led_pwm: table vectors, directed sequences and
// randomized traffic against a behavioural reference model.
module tb_io_led_pwm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  st_we_io;
    logic [9:0]  st_adr_io;
    logic [31:0] st_data_io;
    logic [2:0]  led_in;
    logic [2:0]  rgb_pwm;

    always #5 clk = ~clk;

    io_led_pwm #(.OUT_INV(1'b0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .st_we_io   (st_we_io),
        .st_adr_io  (st_adr_io),
        .st_data_io (st_data_io),
        .led_in     (led_in),
        .rgb_pwm    (rgb_pwm)
    );

    int nvec = 0;
    int nerr = 0;

    // Reference model state.
    int       m_pend [3];
    int       m_act  [3];
    int       m_presc = 0;
    int       m_pc = 0;
    int       m_pwm = 0;
    int       m_half = 0;
    int       m_frames = 0;
    bit       m_en = 0;
    bit       m_phase = 1;
    logic [2:0] m_rgb = 3'b000;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic bit model_fe_next();
        return rst_n && (m_pc >= m_presc) && (m_pwm == 255);
    endfunction

    // One clock of behaviour, from the values present before the edge.
    task automatic model_step();
        bit tick;
        bit fe;
        int hp;
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                m_pend[i] = 255;
                m_act[i]  = 255;
            end
            m_presc = 0; m_pc = 0; m_pwm = 0;
            m_half = 0; m_en = 0; m_phase = 1; m_frames = 0;
            m_rgb = 3'b000;
            return;
        end
        tick = (m_pc >= m_presc);
        fe   = tick && (m_pwm == 255);
        for (int i = 0; i < 3; i++) begin
            m_rgb[i] = led_in[i] && m_phase &&
                       (m_act[i] == 255 || m_pwm < m_act[i]);
        end
        hp = (m_half == 0) ? 1 : m_half;
        if (!m_en) begin
            m_frames = 0;
            m_phase  = 1;
        end else if (fe) begin
            m_frames++;
            if (m_frames >= hp) begin
                m_frames = 0;
                m_phase  = !m_phase;
            end
        end
        if (fe) begin
            for (int i = 0; i < 3; i++) m_act[i] = m_pend[i];
        end
        m_pc = tick ? 0 : m_pc + 1;
        if (tick) m_pwm = (m_pwm + 1) % 256;
        if (st_adr_io == 10'd1) begin
            for (int i = 0; i < 3; i++) begin
                if (st_we_io[i]) m_pend[i] = int'(st_data_io[8*i +: 8]);
            end
        end else if (st_adr_io == 10'd2) begin
            if (st_we_io[0]) m_presc = (m_presc & 'hFF00) | int'(st_data_io[7:0]);
            if (st_we_io[1]) m_presc = (m_presc & 'h00FF) | (int'(st_data_io[15:8]) << 8);
        end else if (st_adr_io == 10'd3) begin
            if (st_we_io[0]) m_en = st_data_io[0];
            if (st_we_io[1]) m_half = int'(st_data_io[15:8]);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("model", {29'd0, rgb_pwm}, {29'd0, m_rgb});
    endtask

    task automatic idle();
        st_we_io   = 4'd0;
        st_adr_io  = 10'd0;
        st_data_io = 32'd0;
    endtask

    task automatic wr(input logic [9:0] adr, input logic [3:0] we,
                      input logic [31:0] data);
        st_adr_io  = adr;
        st_we_io   = we;
        st_data_io = data;
        cycle();
        idle();
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic count_on(input int n, output int r, output int g,
                            output int b);
        r = 0; g = 0; b = 0;
        for (int k = 0; k < n; k++) begin
            cycle();
            r += int'(rgb_pwm[0]);
            g += int'(rgb_pwm[1]);
            b += int'(rgb_pwm[2]);
        end
    endtask

    // Advance until rgb_pwm[0] reaches the wanted level after the other.
    task automatic wait_edge(input bit lvl, input int bound,
                             output bit ok);
        bit prev;
        ok = 0;
        prev = rgb_pwm[0];
        for (int k = 0; k < bound; k++) begin
            cycle();
            if (rgb_pwm[0] == lvl && prev != lvl) begin
                ok = 1;
                break;
            end
            prev = rgb_pwm[0];
        end
    endtask

    // Cycles rgb_pwm[0] stays at its current level, including now.
    task automatic run_len(input int bound, output int len);
        bit lvl;
        lvl = rgb_pwm[0];
        len = 1;
        for (int k = 0; k < bound; k++) begin
            cycle();
            if (rgb_pwm[0] != lvl) break;
            len++;
        end
    endtask

    typedef struct {
        logic        rst_n;
        logic [3:0]  we;
        logic [9:0]  adr;
        logic [31:0] data;
        logic [2:0]  led;
        logic [2:0]  exp;
    } vec_t;

    vec_t tbl [11];

    initial begin
        int r, g, b, len;
        bit ok;

        tbl[0]  = '{1'b0, 4'h0, 10'd0, 32'h0, 3'b111, 3'b000};
        tbl[1]  = '{1'b1, 4'h0, 10'd0, 32'h0, 3'b111, 3'b111};
        tbl[2]  = '{1'b1, 4'h0, 10'd0, 32'h0, 3'b101, 3'b101};
        tbl[3]  = '{1'b1, 4'h0, 10'd0, 32'h0, 3'b010, 3'b010};
        tbl[4]  = '{1'b1, 4'hF, 10'd0, 32'h0, 3'b111, 3'b111};
        tbl[5]  = '{1'b1, 4'h0, 10'd0, 32'h0, 3'b111, 3'b111};
        tbl[6]  = '{1'b1, 4'hF, 10'd4, 32'h0, 3'b111, 3'b111};
        tbl[7]  = '{1'b1, 4'h0, 10'd0, 32'h0, 3'b110, 3'b110};
        tbl[8]  = '{1'b1, 4'h0, 10'd0, 32'h0, 3'b000, 3'b000};
        tbl[9]  = '{1'b0, 4'h0, 10'd0, 32'h0, 3'b111, 3'b000};
        tbl[10] = '{1'b1, 4'h0, 10'd0, 32'h0, 3'b111, 3'b111};

        led_in = 3'b111;
        do_reset();
        check("reset_pins", {29'd0, rgb_pwm}, 32'd0);

        for (int i = 0; i < 11; i++) begin
            rst_n      = tbl[i].rst_n;
            st_we_io   = tbl[i].we;
            st_adr_io  = tbl[i].adr;
            st_data_io = tbl[i].data;
            led_in     = tbl[i].led;
            cycle();
            check($sformatf("tbl%0d", i), {29'd0, rgb_pwm},
                  {29'd0, tbl[i].exp});
        end
        idle();
        rst_n  = 1'b1;
        led_in = 3'b111;

        // Duty pattern R=0, G=0x80, B=0x40.
        do_reset();
        wr(10'd1, 4'hF, 32'h0040_8000);
        repeat (512) cycle();
        count_on(256, r, g, b);
        check("duty_r", r, 0);
        check("duty_g", g, 128);
        check("duty_b", b, 64);

        // Duty write in the frame_end cycle waits one more frame.
        ok = 0;
        for (int k = 0; k < 300; k++) begin
            if (model_fe_next()) begin
                ok = 1;
                break;
            end
            cycle();
        end
        check("fe_found", ok, 1);
        wr(10'd1, 4'hF, 32'h0);
        count_on(256, r, g, b);
        check("fe_old_g", g, 128);
        check("fe_old_b", b, 64);
        count_on(256, r, g, b);
        check("fe_new_rgb", r + g + b, 0);

        // Prescale shrunk below the running count.
        do_reset();
        wr(10'd1, 4'hF, 32'h0080_8080);
        wr(10'd2, 4'h3, 32'd3);
        ok = 0;
        for (int k = 0; k < 10; k++) begin
            if (m_pc == 2) begin
                ok = 1;
                break;
            end
            cycle();
        end
        check("presc_sync", ok, 1);
        wr(10'd2, 4'h3, 32'd1);
        repeat (1200) cycle();
        wait_edge(1'b1, 1200, ok);
        check("presc_rise", ok, 1);
        run_len(2000, len);
        check("presc_high", len, 256);
        run_len(2000, len);
        check("presc_low", len, 256);

        // Blink half=2 frames at prescale 0.
        do_reset();
        wr(10'd3, 4'h3, 32'h0000_0201);
        wait_edge(1'b0, 1200, ok);
        check("blink_fall", ok, 1);
        run_len(2000, len);
        check("blink_off", len, 512);
        run_len(2000, len);
        check("blink_on", len, 512);
        repeat (100) cycle();
        check("blink_mid_off", {29'd0, rgb_pwm}, 32'd0);
        wr(10'd3, 4'h1, 32'h0);
        repeat (2) cycle();
        check("blink_disable", {29'd0, rgb_pwm}, 32'd7);

        // Byte enables and foreign addresses.
        do_reset();
        wr(10'd1, 4'b0010, 32'hFFFF_1100);
        repeat (512) cycle();
        count_on(256, r, g, b);
        check("be_r", r, 256);
        check("be_g", g, 17);
        check("be_b", b, 256);
        wr(10'd0, 4'hF, 32'h0);
        wr(10'd9, 4'hF, 32'h0);
        repeat (600) cycle();
        count_on(256, r, g, b);
        check("adr0_r", r, 256);
        check("adr0_g", g, 17);
        check("adr0_b", b, 256);

        // Randomized traffic checked cycle by cycle against the model.
        do_reset();
        for (int k = 0; k < 20000; k++) begin
            idle();
            rst_n  = ($urandom_range(2999, 0) != 0);
            led_in = 3'($urandom);
            if ($urandom_range(31, 0) == 0) begin
                st_adr_io  = 10'($urandom_range(4, 0));
                st_we_io   = 4'($urandom);
                st_data_io = $urandom;
                if (st_adr_io == 10'd2)
                    st_data_io[15:0] = 16'($urandom_range(3, 0));
                if (st_adr_io == 10'd3)
                    st_data_io[15:8] = 8'($urandom_range(3, 0));
            end
            cycle();
        end
        idle();
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
